i2c_slave_regs: RTL and testbench
=================================

Name: i2c_slave_regs

Overview:
- Parametrised I2C target with an internal register bank of DEPTH 8-bit registers and an auto-incrementing register pointer.
- Supports multi-byte burst writes and reads, repeated START, and address/pointer NACK.
- Adds a host-side port: local logic can write and read the bank, and is notified of every I2C write.
- Sits on the shared open-drain bus next to other I2C targets; successor to the single-byte test target.

Parameters:
- ADDRESS, 7'h00, 7-bit target address matched against the first byte after START.
- DEPTH, 16, number of registers (2..256); pointer range 0..DEPTH-1.
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk  input  1  system clock; must be >= 8x SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- sda  inout  1  I2C data; driven only 0 or z.
- scl  input  1  I2C clock; no clock stretching.
- host_we  input  1  host write strobe.
- host_addr  input  8  host register index; index >= DEPTH is ignored on writes and reads 8'h00.
- host_wdata  input  8  host write data.
- host_rdata  output  8  registered read of reg[host_addr], 1-cycle latency.
- wr_valid  output  1  1-cycle pulse when an I2C byte is committed to the bank.
- wr_addr  output  8  index written; valid with wr_valid.
- wr_data  output  8  byte written; valid with wr_valid.
- busy  output  1  high from a matched address ACK until STOP or a return to IDLE.
- nack_err  output  1  sticky; set on a pointer-out-of-range NACK; cleared by the next START.

Behaviour:
- Reset: all outputs 0, all registers = RESET_VAL, pointer 0, sda released (z), state IDLE.
- Synchronisation: scl and sda each pass a 2-FF synchroniser. All edge detection uses the synced signals.
- START: synced sda falls while synced scl is high. Honoured in every state, including mid-byte (repeated START). It always goes to ADDR, bit index 7, sda released.
- STOP: synced sda rises while synced scl is high. From any state it goes to IDLE, busy=0, sda released.
- Bit timing: SDA is sampled on the scl rising edge. The target changes SDA in the cycle after the scl falling edge is detected.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first. If addr[7:1]==ADDRESS, go to ADDR_ACK; otherwise go to IDLE with no ACK and sda left z.
  - ADDR_ACK: drive 0 for one SCL period; set busy=1. R/W=0 goes to PTR; R/W=1 goes to RDATA, loading shift register with reg[pointer].
  - PTR: shift 8 bits. If value < DEPTH, pointer=value and go to PTR_ACK. Otherwise NACK (sda z), set nack_err, go to WAIT_STOP with pointer unchanged.
  - PTR_ACK: drive 0 for one SCL period, then go to WDATA.
  - WDATA: shift 8 bits, then go to WDATA_ACK. On entering WDATA_ACK (the ACK drive cycle):
    - write reg[pointer];
    - pulse wr_valid with wr_addr=pointer and wr_data=byte;
    - pointer = pointer+1, wrapping DEPTH-1 to 0.
    After the ACK, return to WDATA.
  - RDATA: drive bit 7 first; a 0 bit drives 0, a 1 bit drives z. After bit 0, release sda and go to MACK.
  - MACK: sample sda on the scl rising edge.
    - 0 (ACK): pointer++ (wrapping), reload shift register with reg[new pointer], go to RDATA.
    - 1 (NACK): pointer++ (wrapping), go to WAIT_STOP.
  - WAIT_STOP: sda z; wait for STOP or START.
- Read snapshot: the byte is captured when the shift register loads. Host writes after the load do not alter the byte in flight.
- Collision: host_we and an I2C commit to the same index in the same cycle means the I2C write wins and the host write is dropped. Different indices both take effect.
- Pointer persists across transactions; a read without a preceding pointer write continues from the last pointer.
- Reset asserted mid-transfer releases sda immediately (asynchronous). A bus master sees NACK or a released line.

Test Plan:
- Write burst: START, 0x54 (ADDRESS=0x2A, W), pointer 0x03, data 0xA1 0xB2, STOP → three ACKs; reg[3]=0xA1, reg[4]=0xB2; two wr_valid pulses (addr 3 then 4); busy falls after STOP.
- Read with repeated START: write pointer 0x03, repeated START, 0x55, master ACKs one byte and NACKs the second → bus reads 0xA1, 0xB2; pointer ends at 5.
- Wrap: DEPTH=16, pointer 0x0F, write 0x11 0x22 → reg[15]=0x11, reg[0]=0x22, wr_addr sequence 15, 0.
- Address mismatch: START, 0x40 → sda stays z on the 9th clock; busy stays 0; no wr_valid; next START at 0x54 is ACKed normally.
- Out-of-range pointer: pointer 0x20 with DEPTH=16 → NACK, nack_err=1, following data bytes ignored; the next START clears nack_err.
- Host interaction and reset: host_we to index 4 in the same cycle as an I2C commit to index 4 → I2C value kept. Separately, rst_n low mid-RDATA → sda z within the same cycle, registers = RESET_VAL, outputs 0.

Source files
------------

// File: rtl/i2c_slave_regs_if.sv
// Host-side port of the I2C register target: local bank access plus the
// notification of every byte committed from the I2C side.
interface i2c_slave_regs_if;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  // Local logic that owns the bank from the host side.
  modport master (
    output host_we, host_addr, host_wdata,
    input  host_rdata, wr_valid, wr_addr, wr_data
  );

  // The register target itself.
  modport slave (
    input  host_we, host_addr, host_wdata,
    output host_rdata, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target with a DEPTH x 8-bit register bank and an auto-incrementing
// pointer. Burst writes/reads, repeated START, address and pointer NACK.
// A host port reads/writes the same bank and sees every I2C write.
module i2c_slave_regs #(
  parameter logic [6:0] ADDRESS   = 7'h00,
  parameter int         DEPTH     = 16,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire              sda,
  input  logic             scl,
  i2c_slave_regs_if.slave  host,
  output logic             busy,
  output logic             nack_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK, WAIT_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    scl_sync, sda_sync;
  logic          scl_s, sda_s, scl_q, sda_q;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]    shift_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] ptr_q;
  logic          oe_q, oe_d;
  logic [7:0]    regs [DEPTH];
  logic [7:0]    rd_byte;
  logic          byte_done, ptr_ok;
  logic          cnt_clr, sample, commit, ptr_set, ptr_inc, rd_load, rd_shift, err_set;
  logic          host_ok, host_wr;
  logic [AW-1:0] host_idx;

  // Open drain: the target only ever pulls low; oe_q is async-reset so a
  // reset releases the line at once.
  assign sda = oe_q ? 1'b0 : 1'bz;

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  assign byte_done = (cnt_q == 4'd8);
  assign ptr_ok    = ({1'b0, shift_q} < 9'(DEPTH));
  assign rd_byte   = regs[ptr_q];

  assign host_ok   = ({1'b0, host.host_addr} < 9'(DEPTH));
  assign host_idx  = host.host_addr[AW-1:0];
  // The I2C commit wins a same-index collision; the host write is dropped.
  assign host_wr   = host.host_we && host_ok && !(commit && (host_idx == ptr_q));

  // Two-stage synchronisers plus one history stage for edge detection;
  // idle-high reset values avoid spurious START/STOP after reset.
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath strobes; SDA changes are decided on a detected
  // SCL fall and appear one cycle later through oe_q.
  // NOTE: all outputs get a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    oe_d     = oe_q;
    cnt_clr  = 1'b0;
    sample   = 1'b0;
    commit   = 1'b0;
    ptr_set  = 1'b0;
    ptr_inc  = 1'b0;
    rd_load  = 1'b0;
    rd_shift = 1'b0;
    err_set  = 1'b0;
    if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      oe_d    = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise && !byte_done) sample = 1'b1;
          else if (scl_fall && byte_done) begin
            cnt_clr = 1'b1;
            if (shift_q[7:1] == ADDRESS) begin
              state_d = ADDR_ACK;
              oe_d    = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_clr = 1'b1;
            if (shift_q[0]) begin
              state_d = RDATA;
              rd_load = 1'b1;
              oe_d    = ~rd_byte[7];
            end else begin
              state_d = PTR;
              oe_d    = 1'b0;
            end
          end
        end
        PTR: begin
          if (scl_rise && !byte_done) sample = 1'b1;
          else if (scl_fall && byte_done) begin
            cnt_clr = 1'b1;
            if (ptr_ok) begin
              ptr_set = 1'b1;
              state_d = PTR_ACK;
              oe_d    = 1'b1;
            end else begin
              err_set = 1'b1;
              state_d = WAIT_STOP;
            end
          end
        end
        WDATA: begin
          if (scl_rise && !byte_done) sample = 1'b1;
          else if (scl_fall && byte_done) begin
            cnt_clr = 1'b1;
            commit  = 1'b1;
            ptr_inc = 1'b1;
            state_d = WDATA_ACK;
            oe_d    = 1'b1;
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            cnt_clr = 1'b1;
            state_d = WDATA;
            oe_d    = 1'b0;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              cnt_clr = 1'b1;
              state_d = MACK;
              oe_d    = 1'b0;
            end else begin
              rd_shift = 1'b1;
              oe_d     = ~shift_q[6];
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            ptr_inc = 1'b1;
            if (sda_s) state_d = WAIT_STOP;
            else       sample  = 1'b1;
          end else if (scl_fall && (cnt_q != 4'd0)) begin
            cnt_clr = 1'b1;
            rd_load = 1'b1;
            state_d = RDATA;
            oe_d    = ~rd_byte[7];
          end
        end
        WAIT_STOP: oe_d = 1'b0;
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // Shift register, bit counter, pointer, SDA drive and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q       <= 8'h00;
      cnt_q         <= 4'd0;
      ptr_q         <= '0;
      oe_q          <= 1'b0;
      busy          <= 1'b0;
      nack_err      <= 1'b0;
      host.wr_valid <= 1'b0;
      host.wr_addr  <= 8'h00;
      host.wr_data  <= 8'h00;
    end else begin
      oe_q          <= oe_d;
      host.wr_valid <= commit;
      if (commit) begin
        host.wr_addr <= 8'(ptr_q);
        host.wr_data <= shift_q;
      end
      if (cnt_clr)                cnt_q <= 4'd0;
      else if (sample || rd_shift) cnt_q <= 4'(cnt_q + 4'd1);
      if (rd_load)       shift_q <= rd_byte;
      else if (rd_shift) shift_q <= {shift_q[6:0], 1'b0};
      else if (sample)   shift_q <= {shift_q[6:0], sda_s};
      if (ptr_set)      ptr_q <= shift_q[AW-1:0];
      else if (ptr_inc) ptr_q <= (ptr_q == LAST) ? '0 : AW'(ptr_q + AW'(1));
      if (state_d == IDLE)          busy <= 1'b0;
      else if (state_d == ADDR_ACK) busy <= 1'b1;
      if (start_det)    nack_err <= 1'b0;
      else if (err_set) nack_err <= 1'b1;
    end
  end

  // Register bank with I2C and host write ports.
  // NOTE: the bank is reset like ordinary flops because every register must
  // come out of reset at RESET_VAL; that rules out a RAM macro here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
    end else begin
      if (host_wr) regs[host_idx] <= host.host_wdata;
      if (commit)  regs[ptr_q]    <= shift_q;
    end
  end

  // Registered host read; out-of-range indices read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       host.host_rdata <= 8'h00;
    else if (host_ok) host.host_rdata <= regs[host_idx];
    else              host.host_rdata <= 8'h00;
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-banged I2C master, host-port
// accesses and a log of wr_valid notifications, all against hand values.
module tb_i2c_slave_regs;
  localparam logic [6:0] ADDRESS = 7'h2A;
  localparam int         DEPTH   = 16;
  localparam int         Q       = 5;   // quarter SCL period in clk cycles

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic scl     = 1'b1;
  logic sda_low = 1'b0;
  wire  sda;
  logic busy, nack_err;
  int   n_checks = 0;
  int   n_fail   = 0;
  wr_t  wr_log[$];
  logic ack;
  logic [7:0] rd;
  logic bit_v;

  i2c_slave_regs_if host_bus();

  pullup (sda);
  assign sda = sda_low ? 1'b0 : 1'bz;

  i2c_slave_regs #(.ADDRESS(ADDRESS), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .sda(sda), .scl(scl),
    .host(host_bus), .busy(busy), .nack_err(nack_err)
  );

  always #5 clk = ~clk;

  // Record every committed I2C write.
  always @(negedge clk)
    if (host_bus.wr_valid) wr_log.push_back({host_bus.wr_addr, host_bus.wr_data});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic m_start();
    sda_low = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    sda_low = 1'b1; wait_q();
    scl = 1'b0;
  endtask

  task automatic m_stop();
    wait_q(); sda_low = 1'b1;
    wait_q(); scl = 1'b1;
    wait_q(); sda_low = 1'b0;
    wait_q();
  endtask

  // Optional host write landing in the commit cycle of this byte.
  task automatic m_write(input logic [7:0] b, output logic a, input logic coll,
                         input logic [7:0] c_addr, input logic [7:0] c_data);
    for (int i = 7; i >= 0; i--) begin
      wait_q(); sda_low = ~b[i];
      wait_q(); scl = 1'b1;
      wait_q(); wait_q(); scl = 1'b0;
    end
    if (coll) begin
      repeat (2) @(negedge clk);
      host_bus.host_we = 1'b1; host_bus.host_addr = c_addr; host_bus.host_wdata = c_data;
      @(negedge clk);
      host_bus.host_we = 1'b0;
      repeat (Q - 3) @(negedge clk);
    end else begin
      wait_q();
    end
    sda_low = 1'b0;
    wait_q(); scl = 1'b1;
    wait_q(); a = (sda === 1'b0);
    wait_q(); scl = 1'b0;
  endtask

  task automatic m_wr(input logic [7:0] b, output logic a);
    m_write(b, a, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic m_read_bit(output logic b);
    wait_q(); sda_low = 1'b0;
    wait_q(); scl = 1'b1;
    wait_q(); b = sda;
    wait_q(); scl = 1'b0;
  endtask

  task automatic m_read(output logic [7:0] d, input logic give_ack);
    for (int i = 7; i >= 0; i--) m_read_bit(d[i]);
    wait_q(); sda_low = give_ack;
    wait_q(); scl = 1'b1;
    wait_q(); wait_q(); scl = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_bus.host_we = 1'b1; host_bus.host_addr = a; host_bus.host_wdata = d;
    @(negedge clk);
    host_bus.host_we = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d);
    host_bus.host_addr = a;
    @(negedge clk);
    d = host_bus.host_rdata;
  endtask

  task automatic expect_wr(input string tag, input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    if (wr_log.size() > 0) e = wr_log.pop_front();
    else                   e = 16'hxxxx;
    check({tag, "_addr"}, e.addr, a);
    check({tag, "_data"}, e.data, d);
  endtask

  task automatic check_reg(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] v;
    host_read(a, v);
    check(tag, v, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    host_bus.host_we = 1'b0; host_bus.host_addr = 8'h00; host_bus.host_wdata = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_sda", sda, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_nack_err", nack_err, 1'b0);
    check("rst_wr_valid", host_bus.wr_valid, 1'b0);
    check("rst_rdata", host_bus.host_rdata, 8'h00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write burst: pointer 3, data A1 B2.
    m_start();
    m_wr(8'h54, ack); check("wb_addr_ack", ack, 1'b1);
    check("wb_busy", busy, 1'b1);
    m_wr(8'h03, ack); check("wb_ptr_ack", ack, 1'b1);
    m_wr(8'hA1, ack); check("wb_d0_ack", ack, 1'b1);
    m_wr(8'hB2, ack); check("wb_d1_ack", ack, 1'b1);
    m_stop();
    check("wb_busy_after_stop", busy, 1'b0);
    check_reg("wb_reg3", 8'd3, 8'hA1);
    check_reg("wb_reg4", 8'd4, 8'hB2);
    check("wb_wr_count", wr_log.size(), 2);
    expect_wr("wb_wr0", 8'd3, 8'hA1);
    expect_wr("wb_wr1", 8'd4, 8'hB2);

    // Read with repeated START; then a pointer-less read shows pointer 5.
    host_write(8'd5, 8'h5C);
    m_start();
    m_wr(8'h54, ack); check("rd_addr_ack", ack, 1'b1);
    m_wr(8'h03, ack); check("rd_ptr_ack", ack, 1'b1);
    m_start();
    m_wr(8'h55, ack); check("rd_raddr_ack", ack, 1'b1);
    m_read(rd, 1'b1); check("rd_byte0", rd, 8'hA1);
    m_read(rd, 1'b0); check("rd_byte1", rd, 8'hB2);
    m_stop();
    m_start();
    m_wr(8'h55, ack); check("rd_cont_ack", ack, 1'b1);
    m_read(rd, 1'b0); check("rd_cont_ptr5", rd, 8'h5C);
    m_stop();

    // Pointer wrap at DEPTH-1.
    m_start();
    m_wr(8'h54, ack);
    m_wr(8'h0F, ack); check("wrap_ptr_ack", ack, 1'b1);
    m_wr(8'h11, ack);
    m_wr(8'h22, ack); check("wrap_d1_ack", ack, 1'b1);
    m_stop();
    check_reg("wrap_reg15", 8'd15, 8'h11);
    check_reg("wrap_reg0", 8'd0, 8'h22);
    expect_wr("wrap_wr0", 8'd15, 8'h11);
    expect_wr("wrap_wr1", 8'd0, 8'h22);

    // Address mismatch, then a normal address.
    m_start();
    m_wr(8'h40, ack); check("mis_no_ack", ack, 1'b0);
    check("mis_busy", busy, 1'b0);
    m_stop();
    check("mis_no_wr", wr_log.size(), 0);
    m_start();
    m_wr(8'h54, ack); check("mis_next_ack", ack, 1'b1);
    m_stop();

    // Out-of-range pointer.
    m_start();
    m_wr(8'h54, ack);
    m_wr(8'h20, ack); check("oor_ptr_nack", ack, 1'b0);
    check("oor_nack_err", nack_err, 1'b1);
    m_wr(8'h99, ack); check("oor_data_nack", ack, 1'b0);
    check("oor_no_wr", wr_log.size(), 0);
    m_start();
    check("oor_err_cleared", nack_err, 1'b0);
    m_wr(8'h54, ack); check("oor_restart_ack", ack, 1'b1);
    m_stop();
    check_reg("oor_reg0_kept", 8'd0, 8'h22);

    // Host collisions: same index (I2C wins), different index (both land).
    m_start();
    m_wr(8'h54, ack);
    m_wr(8'h04, ack);
    m_write(8'hC4, ack, 1'b1, 8'd4, 8'h77);
    m_write(8'hC5, ack, 1'b1, 8'd9, 8'h99);
    m_stop();
    check_reg("coll_reg4", 8'd4, 8'hC4);
    check_reg("coll_reg5", 8'd5, 8'hC5);
    check_reg("coll_reg9", 8'd9, 8'h99);
    expect_wr("coll_wr0", 8'd4, 8'hC4);
    expect_wr("coll_wr1", 8'd5, 8'hC5);

    // Host index beyond DEPTH is ignored and reads zero.
    host_write(8'h10, 8'hEE);
    check_reg("host_oor_read", 8'h10, 8'h00);
    check_reg("host_oor_no_alias", 8'd0, 8'h22);

    // Read snapshot: host overwrites reg3 after the byte was loaded.
    m_start();
    m_wr(8'h54, ack);
    m_wr(8'h03, ack);
    m_start();
    m_wr(8'h55, ack);
    repeat (4) @(negedge clk);
    host_write(8'd3, 8'h3C);
    m_read(rd, 1'b0); check("snap_byte", rd, 8'hA1);
    m_stop();
    check_reg("snap_reg3", 8'd3, 8'h3C);

    // Reset in the middle of RDATA while the target drives a 0 bit.
    m_start();
    m_wr(8'h54, ack);
    m_wr(8'h04, ack);
    m_start();
    m_wr(8'h55, ack);
    m_read_bit(bit_v); check("mid_bit7", bit_v, 1'b1);
    m_read_bit(bit_v); check("mid_bit6", bit_v, 1'b1);
    wait_q(); wait_q();
    check("mid_bit5_driven", sda, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sda", sda, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_wr_valid", host_bus.wr_valid, 1'b0);
    scl = 1'b1; sda_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reg("mid_rst_reg4", 8'd4, 8'h00);
    check_reg("mid_rst_reg9", 8'd9, 8'h00);
    host_write(8'd0, 8'hAB);
    m_start();
    m_wr(8'h55, ack); check("post_rst_ack", ack, 1'b1);
    m_read(rd, 1'b0); check("post_rst_ptr0", rd, 8'hAB);
    m_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
